dt_result_scan: RTL

//   Downstream stage of the distance-transform engine. On the rising edge of DT done, scans the 128x128 8-bit result RAM in raster order.

---
 rtl/dt_pkg.sv | 15 +
 rtl/dt_skid_fifo.sv | 45 ++++
 rtl/dt_result_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared types and geometry for the distance-transform result scanner.
package dt_pkg;
  localparam int IMG_W_LOG2 = 7;
  localparam int IMG_H_LOG2 = 7;
  localparam int DW         = 8;
  localparam int ADDR_W     = 14;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 14'h3FFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } pix_beat_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
endpackage

// File: rtl/dt_skid_fifo.sv
// Two-entry FIFO decoupling RAM read latency from the output stream.
module dt_skid_fifo
  import dt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  pix_beat_t  din_i,
  output pix_beat_t  dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);
  pix_beat_t  mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] cnt_q;
  logic       do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // When full, a push is accepted only alongside a pop (slot freed same edge).
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/dt_result_scan.sv
// Raster scan of the DT result RAM: streams pixels and gathers max/nonzero stats.
// Optional DT_THRESH_EN adds a thresh input filtering streamed pixels.
module dt_result_scan
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dt_done,
`ifdef DT_THRESH_EN
  input  logic [DW-1:0]     thresh,
`endif
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DW-1:0]     res_di,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [DW-1:0]     max_dist,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W:0]   nz_count,
  output logic              stat_valid,
  output logic              scan_done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, cap_addr_q;
  logic              dt_done_q, inflight_q;
  logic [DW-1:0]     max_q;
  logic [ADDR_W-1:0] max_addr_q;
  logic [ADDR_W:0]   nz_q;
  logic              stat_valid_q;
  logic              start, issue, pop, pass, fifo_empty, fifo_full_unused;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  pix_beat_t         head, cap_beat;

`ifdef DT_THRESH_EN
  logic [DW-1:0] thresh_q;
  assign pass = (res_di >= thresh_q);
`else
  assign pass = 1'b1;
`endif

  assign start = (state_q == IDLE) & dt_done & ~dt_done_q;
  assign pop   = out_valid & out_ready;
  // Credit counts the slot freed by this cycle's pop so ready=1 sustains 1 beat/cycle.
  assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == SCAN) && (occ < 3'd2);

  assign res_rd   = issue;
  assign res_addr = rd_ptr_q;
  assign cap_beat = '{addr: cap_addr_q, data: res_di};

  dt_skid_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q & pass),
    .pop_i   (pop),
    .din_i   (cap_beat),
    .dout_o  (head),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid  = ~fifo_empty;
  assign out_data   = head.data;
  assign out_addr   = head.addr;
  assign out_last   = out_valid & (head.addr == LAST_ADDR);
  assign max_dist   = max_q;
  assign max_addr   = max_addr_q;
  assign nz_count   = nz_q;
  assign stat_valid = stat_valid_q;
  assign scan_done  = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE:  if (start) begin
               state_d  = SCAN;
               rd_ptr_d = '0;
             end
      SCAN:  if (issue) begin
               if (rd_ptr_q == LAST_ADDR) state_d = DRAIN;
               else                       rd_ptr_d = rd_ptr_q + 1'b1;
             end
      DRAIN: if (!inflight_q && fifo_empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      cap_addr_q   <= '0;
      dt_done_q    <= 1'b0;
      inflight_q   <= 1'b0;
      max_q        <= '0;
      max_addr_q   <= '0;
      nz_q         <= '0;
      stat_valid_q <= 1'b0;
`ifdef DT_THRESH_EN
      thresh_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      dt_done_q  <= dt_done;
      inflight_q <= issue;
      if (issue) cap_addr_q <= rd_ptr_q;
`ifdef DT_THRESH_EN
      if (start) thresh_q <= thresh;
`endif
      if (start) begin
        max_q        <= '0;
        max_addr_q   <= '0;
        nz_q         <= '0;
        stat_valid_q <= 1'b0;
      end else begin
        // Stats see every captured pixel, filtered or not; strict > keeps the first max.
        if (inflight_q) begin
          if (res_di > max_q) begin
            max_q      <= res_di;
            max_addr_q <= cap_addr_q;
          end
          nz_q <= nz_q + {{ADDR_W{1'b0}}, (res_di != '0)};
        end
        if (state_q == DRAIN && state_d == DONE) stat_valid_q <= 1'b1;
      end
    end
  end
endmodule
